loadable_dff: RTL and testbench

//   Single-bit (WIDTH-configurable) D flip-flop with a synchronous load enable and a

---
 rtl/loadable_dff.sv | 59 +++++
 tb/tb_loadable_dff.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/loadable_dff.sv
// loadable_dff: WIDTH-bit D flip-flop with a synchronous load enable and a
// synchronous active-low clear. Clear takes priority over load, and load takes
// priority over hold. The output comes straight from the flop, so there is no
// combinational path from any input to out.
//
// register_8bit: an 8-bit loadable register built from eight WIDTH=1
// loadable_dff cells, one per bit. The cells are connected by position,
// following the fixed cell port order (in, clk, clr, load, out).
`timescale 1ns / 1ns

module loadable_dff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] in,
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // Next state when not clearing: capture in on load, otherwise keep the stored value
    always_comb begin
        out_d = out_q;
        if (load) begin
            out_d = in;
        end
    end

    // State register; the active-low clear is sampled on the edge and overrides load
    always_ff @(posedge clk) begin
        if (!clr) begin
            out_q <= RESET_VALUE;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

module register_8bit (
    input  logic [7:0] in,
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    output logic [7:0] out
);

    // One single-bit storage cell per bit, all sharing clock, clear and load
    for (genvar i = 0; i < 8; i++) begin : gen_bit
        loadable_dff u_cell (in[i], clk, clr, load, out[i]);
    end

endmodule

// File: tb/tb_loadable_dff.sv
// Testbench for loadable_dff (WIDTH=1, WIDTH=8, WIDTH=8 with a non-zero reset
// value) and for register_8bit. Directed sequences cover clear, load, hold,
// clear-over-load priority and mid-cycle clear. They are followed by random
// cycles that are compared against a reference model of the flop rules.
`timescale 1ns / 1ns

module tb_loadable_dff;

    localparam logic [7:0] ALT_RESET = 8'h3C;

    logic       clk;
    logic       clr;
    logic       load;
    logic       in1;
    logic [7:0] in8;
    logic       out1;
    logic [7:0] out8;
    logic [7:0] outAlt;
    logic [7:0] outReg;

    logic       exp1;
    logic [7:0] exp8;
    logic [7:0] expAlt;

    int checkCount;
    int errorCount;

    loadable_dff #(.WIDTH(1)) dut1 (
        .in(in1), .clk(clk), .clr(clr), .load(load), .out(out1)
    );

    loadable_dff #(.WIDTH(8)) dut8 (
        .in(in8), .clk(clk), .clr(clr), .load(load), .out(out8)
    );

    loadable_dff #(.WIDTH(8), .RESET_VALUE(ALT_RESET)) dutAlt (
        .in(in8), .clk(clk), .clr(clr), .load(load), .out(outAlt)
    );

    register_8bit reg8 (
        .in(in8), .clk(clk), .clr(clr), .load(load), .out(outReg)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every instance against the model's current state
    task automatic checkAll(input string tag);
        checkOutput({tag, "/w1"}, {7'b0, out1}, {7'b0, exp1});
        checkOutput({tag, "/w8"}, out8, exp8);
        checkOutput({tag, "/alt"}, outAlt, expAlt);
        checkOutput({tag, "/reg8"}, outReg, exp8);
    endtask

    // Advance the reference model by one rising edge using the current inputs
    task automatic modelEdge();
        if (!clr) begin
            exp1   = 1'b0;
            exp8   = 8'h00;
            expAlt = ALT_RESET;
        end else if (load) begin
            exp1   = in1;
            exp8   = in8;
            expAlt = in8;
        end
    endtask

    // Drive inputs, let one rising edge pass, then check 1 ns after the edge
    task automatic applyStimulus(input logic c, input logic l, input logic i1,
                                 input logic [7:0] i8, input string tag);
        clr  = c;
        load = l;
        in1  = i1;
        in8  = i8;
        modelEdge();
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        clr  = 1'b1;
        load = 1'b0;
        in1  = 1'b0;
        in8  = 8'h00;
        exp1 = 1'b0;
        exp8 = 8'h00;
        expAlt = ALT_RESET;
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, "clear1");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, "clear2");

        applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, "load55");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h33, "load33");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hCC, "holdCC");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hCC, "loadCC");

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h0F, "hold1");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hF0, "hold2");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "hold3");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, "hold4");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h12, "hold5");

        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, "priority");

        applyStimulus(1'b1, 1'b1, 1'b1, 8'hA7, "preSync");
        #2;
        clr  = 1'b0;
        load = 1'b0;
        #2;
        checkAll("midCycle");
        modelEdge();
        @(posedge clk);
        #1;
        checkAll("syncClear");

        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                          $urandom_range(0, 1), 8'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
